// File: rtl/pipe_latch_pkg.sv
// Shared types for the elastic pipeline register: occupancy/state encoding
// and the stage payload structs that callers cast to and from WIDTH bits.
package pipe_latch_pkg;

    typedef logic [1:0] pipe_occ_t;

    // State values double as the occupancy count.
    typedef enum pipe_occ_t {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } latch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] store_data;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
    } memwb_t;

endpackage

// File: rtl/pipe_latch_if.sv
// Valid/ready handshake bundle around one pipeline register: upstream
// input side, downstream output side and the occupancy count.
interface pipe_latch_if #(
    parameter int WIDTH = 64
);
    import pipe_latch_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    pipe_occ_t        count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_latch.sv
// Elastic pipeline register with flush and optional skid entry; the main
// entry always drives the outputs and holds BUBBLE whenever it is empty.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_EMPTY | nothing held, out_valid=0, main entry holds BUBBLE
// ST_ONE   | main entry valid, skid entry empty
// ST_FULL  | main and skid both valid, in_ready=0 (SKID=1 only)
module pipe_latch
    import pipe_latch_pkg::*;
#(
    parameter int               WIDTH  = 64,
    parameter int               SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      flush,
    pipe_latch_if.slave bus
);

    latch_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_data;
    logic             xfer_in;
    logic             xfer_out;

    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_data  = main_q;
    assign bus.count     = state_q;

    assign xfer_in  = bus.in_valid && bus.in_ready;
    assign xfer_out = bus.out_valid && bus.out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] skid_data_q;
            logic             skid_load;

            // Only a lone accept into a held, stalled main entry overflows.
            assign skid_load = (state_q == ST_ONE) && xfer_in && !xfer_out;

            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    skid_data_q <= BUBBLE;
                end else if (skid_load) begin
                    skid_data_q <= bus.in_data;
                end
            end

            assign skid_data    = skid_data_q;
            assign bus.in_ready = nRST && (state_q != ST_FULL);
        end else begin : g_flat
            assign skid_data    = BUBBLE;
            assign bus.in_ready = nRST && (!bus.out_valid || bus.out_ready);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        case (state_q)
            ST_EMPTY: begin
                if (xfer_in) begin
                    main_d  = bus.in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (xfer_in && xfer_out) begin
                    main_d = bus.in_data;
                end else if (xfer_out) begin
                    main_d  = BUBBLE;
                    state_d = ST_EMPTY;
                end else if (xfer_in && (SKID != 0)) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (xfer_out) begin
                    main_d  = skid_data;
                    state_d = ST_ONE;
                end
            end
            default: begin
                main_d  = BUBBLE;
                state_d = ST_EMPTY;
            end
        endcase
        // Flush wins over any simultaneous transfer in or out.
        if (flush) begin
            main_d  = BUBBLE;
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

endmodule

// File: tb/tb_pipe_latch.sv
// Scoreboard bench for pipe_latch: a SKID=1 and a SKID=0 instance are
// exercised in turn against a FIFO-of-held-words reference model.
module tb_pipe_latch;
    import pipe_latch_pkg::*;

    localparam logic [31:0] BUBBLE = 32'hDEAD_0000;

    logic        clk;
    logic        nrst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        skid_mode;
    logic        mon_en;

    logic        nrst_skid;
    logic        nrst_flat;

    logic        act_in_ready;
    logic        act_out_valid;
    logic [31:0] act_out_data;
    pipe_occ_t   act_count;

    int          n_checks;
    int          n_fail;

    // Words accepted and not yet emitted, oldest first.
    logic [31:0] sb_q[$];

    pipe_latch_if #(.WIDTH(32)) if_skid ();
    pipe_latch_if #(.WIDTH(32)) if_flat ();

    assign nrst_skid = skid_mode ? nrst : 1'b0;
    assign nrst_flat = skid_mode ? 1'b0 : nrst;

    assign if_skid.in_valid  = in_valid;
    assign if_skid.in_data   = in_data;
    assign if_skid.out_ready = out_ready;
    assign if_flat.in_valid  = in_valid;
    assign if_flat.in_data   = in_data;
    assign if_flat.out_ready = out_ready;

    assign act_in_ready  = skid_mode ? if_skid.in_ready  : if_flat.in_ready;
    assign act_out_valid = skid_mode ? if_skid.out_valid : if_flat.out_valid;
    assign act_out_data  = skid_mode ? if_skid.out_data  : if_flat.out_data;
    assign act_count     = skid_mode ? if_skid.count     : if_flat.count;

    pipe_latch #(.WIDTH(32), .SKID(1), .BUBBLE(BUBBLE)) u_skid (
        .CLK   (clk),
        .nRST  (nrst_skid),
        .flush (flush),
        .bus   (if_skid)
    );

    pipe_latch #(.WIDTH(32), .SKID(0), .BUBBLE(BUBBLE)) u_flat (
        .CLK   (clk),
        .nRST  (nrst_flat),
        .flush (flush),
        .bus   (if_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (skid=%0d t=%0t): actual %h required %h", name, skid_mode, $time, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest held word; an idle
    // output must show exactly BUBBLE.
    always @(negedge clk) begin
        if (mon_en) begin
            if (act_out_valid === 1'b1) begin
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_out_valid", {31'd0, act_out_valid}, 32'd0);
                    end else begin
                        chk("out_data", act_out_data, sb_q.pop_front());
                    end
                end
            end else begin
                chk("idle_bubble", act_out_data, BUBBLE);
            end
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] d, input logic ordy,
                         input logic fl, input logic rn);
        logic exp_rdy;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        nrst      = rn;
        #1;
        if (skid_mode)
            exp_rdy = rn && (sb_q.size() < 2);
        else
            exp_rdy = rn && ((sb_q.size() == 0) || ordy);
        chk("in_ready", {31'd0, act_in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, act_out_valid}, {31'd0, (sb_q.size() > 0)});
        chk("count", {30'd0, act_count}, sb_q.size());
        @(posedge clk);
        #1;
        if (!rn || fl)
            sb_q.delete();
        else if (v && exp_rdy)
            sb_q.push_back(d);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb_q.size() > 0; i++)
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("drain_empty", sb_q.size(), 32'd0);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) != 0));
    endtask

    task automatic stream8();
        for (int i = 0; i < 8; i++)
            cycle(1'b1, i, 1'b1, 1'b0, 1'b1);
        drain();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        skid_mode = 1'b1;
        mon_en    = 1'b0;
        nrst      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // SKID=1: reset with a word offered, then streaming.
        cycle(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        stream8();

        // Backpressure: A then B held, C offered while full.
        cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
        chk("bp_out_data_A", act_out_data, 32'hA);
        drain();

        // Flush while full, with a word offered and downstream ready.
        cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h2, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hC, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Mid-stream reset pulse while full, then first word after release.
        cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h2, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h7, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h8, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h9, 1'b1, 1'b0, 1'b1);
        drain();

        // Flush held for several cycles keeps the block empty.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h100 + i, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        random_run(300);
        drain();

        // SKID=0 instance.
        skid_mode = 1'b0;
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h5, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h6, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h6, 1'b0, 1'b0, 1'b1);
        chk("stall_hold_5", act_out_data, 32'h5);
        cycle(1'b1, 32'h6, 1'b1, 1'b0, 1'b1);
        chk("stall_next_6", act_out_data, 32'h6);
        drain();
        stream8();

        cycle(1'b1, 32'h3, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h4, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        random_run(300);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
